// File: rtl/mux_mult_sequencer.sv
// rtl/mux_mult_sequencer.sv - iterative shift-add multiplier, one partial-product row per clock
module mux_mult_sequencer #(
  parameter int N          = 8,
  parameter bit EARLY_TERM = 1'b0,
  localparam int RW        = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic [RW-1:0]  row_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   x_reg;
  logic [N-1:0]   y_reg;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] pp_shift;
  logic [2*N-1:0] acc_next;
  logic           last_row;

  // The single shared row: select x or zero by the current multiplier bit, then align it.
  always_comb begin
    pp_shift = y_reg[row_idx] ? ({{N{1'b0}}, x_reg} << row_idx) : '0;
    acc_next = acc + pp_shift;
    last_row = (row_idx == RW'(N - 1));
    if (EARLY_TERM && (((y_reg >> row_idx) >> 1) == '0)) last_row = 1'b1;
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      acc       <= '0;
      product   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      row_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg   <= x;
            y_reg   <= y;
            acc     <= '0;
            row_idx <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (last_row) begin
            product   <= acc_next;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            row_idx   <= '0;
            state     <= DONE;
          end else begin
            row_idx <= row_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          row_idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_mult_sequencer.sv
// tb/tb_mux_mult_sequencer.sv - scoreboard bench for mux_mult_sequencer, EARLY_TERM 0 and 1
module tb_mux_mult_sequencer;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [7:0]  xs [2];
  logic [7:0]  ys [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] prod [2];
  logic        busy [2];
  logic [2:0]  ridx [2];

  int checks = 0;
  int failures = 0;
  logic [15:0] sq0 [$];
  logic [15:0] sq1 [$];

  always #5 clk = ~clk;

  mux_mult_sequencer #(.N(N), .EARLY_TERM(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .x(xs[0]), .y(ys[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .product(prod[0]), .busy(busy[0]), .row_idx(ridx[0])
  );

  mux_mult_sequencer #(.N(N), .EARLY_TERM(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .x(xs[1]), .y(ys[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .product(prod[1]), .busy(busy[1]), .row_idx(ridx[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int et_lat(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) if (b[i]) return i + 1;
    return 1;
  endfunction

  task automatic push_exp(input int d, input logic [15:0] v);
    if (d == 0) sq0.push_back(v);
    else        sq1.push_back(v);
  endtask

  task automatic pop_check(input int d);
    logic [15:0] e;
    if ((d == 0 && sq0.size() == 0) || (d == 1 && sq1.size() == 0)) begin
      check("scoreboard_empty_on_output", 1, 0);
    end else begin
      e = (d == 0) ? sq0.pop_front() : sq1.pop_front();
      check("product", prod[d], e);
    end
  endtask

  task automatic do_op(input int d, input logic [7:0] a, input logic [7:0] b,
                       input int stall);
    int lat;
    int exp_lat;
    logic [15:0] p0;
    exp_lat = (d == 0) ? N : et_lat(b);
    @(negedge clk);
    check("in_ready_idle", in_ready[d], 1);
    in_valid[d] = 1'b1;
    xs[d] = a;
    ys[d] = b;
    push_exp(d, 16'(a * b));
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    xs[d] = 8'($urandom);
    ys[d] = 8'($urandom);
    lat = 0;
    if (!out_valid[d]) check("busy_in_run", busy[d], 1);
    while (!out_valid[d] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    if (!out_valid[d]) return;
    check("busy_done", busy[d], 0);
    check("row_idx_done", ridx[d], 0);
    pop_check(d);
    p0 = prod[d];
    for (int i = 0; i < stall; i++) begin
      in_valid[d] = 1'b1;
      @(posedge clk);
      #1;
      check("stall_out_valid", out_valid[d], 1);
      check("stall_product", prod[d], p0);
      check("stall_in_ready", in_ready[d], 0);
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    check("post_hs_out_valid", out_valid[d], 0);
    check("post_hs_in_ready", in_ready[d], 1);
    check("post_hs_product_kept", prod[d], p0);
  endtask

  initial begin
    int seen;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; xs[d] = '0; ys[d] = '0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("rst_in_ready", in_ready[d], 1);
      check("rst_out_valid", out_valid[d], 0);
      check("rst_product", prod[d], 0);
      check("rst_busy", busy[d], 0);
      check("rst_row_idx", ridx[d], 0);
    end

    do_op(0, 8'd3, 8'd5, 0);
    do_op(0, 8'd255, 8'd255, 0);
    do_op(0, 8'd0, 8'd200, 1);
    do_op(1, 8'd9, 8'd0, 0);
    do_op(1, 8'd9, 8'd1, 0);
    do_op(1, 8'd7, 8'h10, 0);
    do_op(1, 8'd255, 8'd255, 2);
    do_op(0, 8'd21, 8'd13, 6);
    do_op(1, 8'd5, 8'h40, 6);
    do_op(0, 8'd2, 8'd3, 0);

    // Abort an operation mid-RUN: nothing is pushed, so any output would fail the scoreboard.
    @(negedge clk);
    in_valid[0] = 1'b1; xs[0] = 8'd9; ys[0] = 8'hff;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_row_idx", ridx[0], 3);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_in_ready", in_ready[0], 1);
    check("abort_busy", busy[0], 0);
    check("abort_row_idx_zero", ridx[0], 0);
    check("abort_product", prod[0], 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid[0]) seen++;
    end
    check("abort_no_out_valid", seen, 0);
    do_op(0, 8'd12, 8'd11, 0);

    for (int i = 0; i < 300; i++) begin
      do_op(0, 8'($urandom), 8'($urandom), $urandom_range(0, 3));
      do_op(1, 8'($urandom), 8'($urandom >> ($urandom_range(0, 8))), $urandom_range(0, 3));
    end

    check("sq0_drained", sq0.size(), 0);
    check("sq1_drained", sq1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
